// File: rtl/aes_pkg.sv
// Shared AES-128 constants and helpers for the iterative encryption core.
// Holds the S-box, the round-constant table, the FSM state type and xtime.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed directly by the round counter; entries 0 and 11..15 are never used in RUN.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Byte i of a block sits at bits [8*i +: 8], column-major (row = i%4, column = i/4).
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [0:127] state_in,
    input  logic [0:127] round_key,
    input  logic         last_round,
    output logic [0:127] state_out
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        // NOTE: every variable gets a value on every pass through this block, so no latch is inferred.
        state_out = '0;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;

        for (int i = 0; i < 16; i++) begin
            sb[i] = SBOX[state_in[8*i +: 8]];
        end

        // Row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
            end
        end

        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c + 1];
            a2 = sr[4*c + 2];
            a3 = sr[4*c + 3];
            mc[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end

        for (int i = 0; i < 16; i++) begin
            state_out[8*i +: 8] = (last_round ? sr[i] : mc[i]) ^ round_key[8*i +: 8];
        end
    end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Define AES_ENC_LAST_KEY_OUT_EN to expose the registered round-10 key on last_key.
module aes_enc_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] pt,
    input  logic [0:127] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] ct
`ifdef AES_ENC_LAST_KEY_OUT_EN
    ,
    output logic [0:127] last_key
`endif
);

    fsm_t         fsm_q, fsm_d;
    logic [0:127] state_q;
    logic [0:127] rk_q;
    logic [0:127] nk;
    logic [0:127] round_out;
    logic [0:31]  g_word;
    logic [3:0]   rnd_q;
    logic         last_round;
    logic         accept;

    assign last_round = (rnd_q == 4'd10);
    assign accept     = (fsm_q == IDLE) && in_valid;

    // Handshake outputs depend only on registered state (and reset holds in_ready low).
    assign in_ready  = (fsm_q == IDLE) && !rst;
    assign out_valid = (fsm_q == DONE);
    assign ct        = state_q;

    // Next round key: w4 = w0 ^ SubWord(RotWord(w3)) ^ rcon, then chained XOR.
    always_comb begin
        g_word = {SBOX[rk_q[104 +: 8]] ^ RCON[rnd_q],
                  SBOX[rk_q[112 +: 8]],
                  SBOX[rk_q[120 +: 8]],
                  SBOX[rk_q[96 +: 8]]};
        nk[0:31]   = rk_q[0:31]   ^ g_word;
        nk[32:63]  = rk_q[32:63]  ^ nk[0:31];
        nk[64:95]  = rk_q[64:95]  ^ nk[32:63];
        nk[96:127] = rk_q[96:127] ^ nk[64:95];
    end

    aes_enc_round u_round (
        .state_in   (state_q),
        .round_key  (nk),
        .last_round (last_round),
        .state_out  (round_out)
    );

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:    if (in_valid)   fsm_d = RUN;
            RUN:     if (last_round) fsm_d = DONE;
            DONE:    if (out_ready)  fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q <= fsm_d;
            if (accept) begin
                state_q <= pt ^ key;
                rnd_q   <= 4'd1;
            end else if (fsm_q == RUN) begin
                state_q <= round_out;
                rnd_q   <= rnd_q + 4'd1;
            end
        end
    end

    // NOTE: rk_q has no reset; it is always loaded at accept before any round reads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            rk_q <= key;
        end else if (fsm_q == RUN) begin
            rk_q <= nk;
        end
    end

`ifdef AES_ENC_LAST_KEY_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_key <= '0;
        end else if (fsm_q == RUN && last_round) begin
            last_key <= nk;
        end
    end
`endif

endmodule
